seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised serial sequence detector, the successor to the fixed 4-bit sequence block in the board top.
//  Pattern length is SEQ_W bits, the pattern is loaded at run time, and overlap or non-overlap mode is selectable.
//  Emits a match pulse, keeps a saturating match count, and drives two active-low 7-seg digits with the low count byte.
//  Instantiated by the board top: serial bits come from SW/KEY logic, o_hex* feed HEX0/HEX1.
// PARAMETERS
//  SEQ_W    4  pattern length in bits (legal 2..8)
//  CNT_W    8  match counter width (legal 8..16)
//  DEF_PAT  4'b1011  pattern after reset (SEQ_W bits wide)
// PORTS
//  CLOCK_50        in   1      system clock, all logic on rising edge
//  RST             in   1      synchronous, active-high reset
//  i_bit_valid     in   1      i_bit is sampled this cycle
//  i_bit           in   1      serial data bit (MSB of pattern arrives first)
//  i_load_pattern  in   1      latch i_pattern and restart detection
//  i_pattern       in   SEQ_W  new pattern value
//  i_overlap       in   1      1 = overlapping matches allowed, 0 = non-overlapping
//  o_match         out  1      one-cycle pulse on detection
//  o_match_count   out  CNT_W  saturating number of matches
//  o_busy          out  1      1 while in HUNT (history full, comparing)
//  o_hex0          out  7      active-low segments {g..a}, count[3:0]
//  o_hex1          out  7      active-low segments {g..a}, count[7:4]
// BEHAVIOUR
//  Reset: pattern=DEF_PAT, shift history=0, fill=0, state=FILL, o_match=0, o_match_count=0, o_busy=0; hex shows "00".
//  History: shift register hist[SEQ_W-1:0]; on a valid bit, hist <= {hist[SEQ_W-2:0], i_bit}.
//  Fill counter fill (0..SEQ_W) counts bits received since the last restart and saturates at SEQ_W.
//  FSM states:
//   - FILL: collect bits; when a valid bit makes fill reach SEQ_W, go to HUNT and compare that same cycle.
//   - HUNT: compare on every valid bit.
//  Compare: match when {hist[SEQ_W-2:0], i_bit} == pattern and the window is full.
//  Latency: o_match is registered and is high exactly one cycle after the clock edge that sampled the last pattern bit.
//  On match:
//   - o_match_count increments on the same edge that sets o_match.
//   - At all-ones the count holds; o_match still pulses.
//   - i_overlap=1: stay in HUNT with the history kept (e.g. 1011011 with pattern 1011 gives 2 matches).
//   - i_overlap=0: fill<=0 and go to FILL; the next match needs SEQ_W fresh bits (1011011 gives 1 match).
//  i_overlap is sampled per bit; changing it mid-stream affects only the next match decision.
//  i_load_pattern:
//   - pattern <= i_pattern; hist <= 0; fill <= 0; state <= FILL; o_match_count <= 0; o_match <= 0.
//   - Takes priority over a simultaneous i_bit_valid; that bit is dropped.
//  RST has priority over everything, including mid-match: o_match is 0 on the cycle after RST.
//  o_busy = (state==HUNT), registered.
//  o_hex0/o_hex1: combinational decode of the registered count, nibbles 0-F (A,b,C,d,E,F glyphs).
//  No bit is consumed when i_bit_valid=0; the state is held.
// STRUCTURE
//  Shared package seq_pkg:
//   - state encoding localparams ST_FILL=1'b0, ST_HUNT=1'b1
//   - 7-seg glyph constants SEG_0..SEG_F
//  Sub-module hex7seg (4-bit in, 7-bit active-low out), instantiated twice.
//  Top-level pieces: history shift register, fill counter, 2-state FSM, saturating counter.
// TESTING
//  1. RST=1 for 2 cycles, then 0 -> o_match_count=0, o_hex0=o_hex1=7'b1000000, o_busy=0.
//  2. Default pattern 1011, i_overlap=1, stream 1011011 -> o_match pulses at bits 4 and 7, count=2, o_hex0=SEG_2.
//  3. Same stream with i_overlap=0 -> single pulse at bit 4, count=1, o_busy returns to 0 after the match.
//  4. Load pattern 4'b0110 with i_bit_valid=1 in the same cycle -> the bit is ignored, count=0.
//     Then 0110 -> one match.
//  5. CNT_W=8: force 256 matches (pattern 1111, overlap, all ones) -> count stops at 8'hFF.
//     o_match still pulses, hex shows "FF".
//  6. Assert RST while the 3rd of 4 pattern bits is valid, then send 1 -> no match.
//     Fill restarts, and a full 1011 is needed afterwards.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the parametrised sequence detector: FSM state
// encoding and active-low 7-segment glyphs, segment order {g,f,e,d,c,b,a}.
package seq_pkg;

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_HUNT = 1'b1;

  typedef enum logic {
    StFill = ST_FILL,
    StHunt = ST_HUNT
  } state_e;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low 7-segment decoder, segment order {g..a}.
module hex7seg
  import seq_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Pure lookup, one glyph per nibble value.
  always_comb begin
    seg_o = SEG_0;
    unique case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with run-time pattern load,
// selectable overlap, saturating match counter and a two-digit hex display
// of the low count byte.
module seq_detector_param
  import seq_pkg::*;
#(
  parameter int unsigned          SEQ_W   = 4,
  parameter int unsigned          CNT_W   = 8,
  parameter logic [SEQ_W-1:0]     DEF_PAT = 4'b1011
) (
  input  logic             CLOCK_50,
  input  logic             RST,
  input  logic             i_bit_valid,
  input  logic             i_bit,
  input  logic             i_load_pattern,
  input  logic [SEQ_W-1:0] i_pattern,
  input  logic             i_overlap,
  output logic             o_match,
  output logic [CNT_W-1:0] o_match_count,
  output logic             o_busy,
  output logic [6:0]       o_hex0,
  output logic [6:0]       o_hex1
);

  localparam int unsigned       FILL_W    = $clog2(SEQ_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(SEQ_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SEQ_W - 1);

  state_e             state_q, state_d;
  logic [SEQ_W-1:0]   pat_q, pat_d;
  logic [SEQ_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q, match_d;

  logic [SEQ_W-1:0]   window;
  logic               window_full;
  logic               hit;

  // The incoming bit completes the window, so comparison happens on the
  // same edge that shifts it in.
  assign window      = {hist_q[SEQ_W-2:0], i_bit};
  assign window_full = (fill_q >= FILL_LAST);
  assign hit         = i_bit_valid && window_full && (window == pat_q);

  // Next-state: pattern load beats a simultaneous bit; idle cycles hold state.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;

    if (i_load_pattern) begin
      pat_d   = i_pattern;
      hist_d  = '0;
      fill_d  = '0;
      state_d = StFill;
      cnt_d   = '0;
    end else if (i_bit_valid) begin
      hist_d = window;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end

      unique case (state_q)
        StFill: if (fill_q == FILL_LAST) state_d = StHunt;
        StHunt: state_d = StHunt;
        default: state_d = StFill;
      endcase

      if (hit) begin
        match_d = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Non-overlap mode demands a fresh full window for the next match.
        if (!i_overlap) begin
          fill_d  = '0;
          state_d = StFill;
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q <= StFill;
      pat_q   <= DEF_PAT;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign o_match       = match_q;
  assign o_match_count = cnt_q;
  assign o_busy        = (state_q == StHunt);

  hex7seg u_hex0 (
    .nibble_i (cnt_q[3:0]),
    .seg_o    (o_hex0)
  );

  hex7seg u_hex1 (
    .nibble_i (cnt_q[7:4]),
    .seg_o    (o_hex1)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed, table-driven bench for seq_detector_param (SEQ_W=4, CNT_W=8).
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_valid;
  logic       bit_in;
  logic       load_pat;
  logic [3:0] pattern;
  logic       overlap;
  logic       match;
  logic [7:0] match_count;
  logic       busy;
  logic [6:0] hex0;
  logic [6:0] hex1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  seq_detector_param #(
    .SEQ_W   (4),
    .CNT_W   (8),
    .DEF_PAT (4'b1011)
  ) dut (
    .CLOCK_50       (clk),
    .RST            (rst),
    .i_bit_valid    (bit_valid),
    .i_bit          (bit_in),
    .i_load_pattern (load_pat),
    .i_pattern      (pattern),
    .i_overlap      (overlap),
    .o_match        (match),
    .o_match_count  (match_count),
    .o_busy         (busy),
    .o_hex0         (hex0),
    .o_hex1         (hex1)
  );

  // Independent glyph table, active-low {g..a}.
  logic [6:0] glyph [16];
  initial begin
    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100;
    glyph[3]  = 7'b0110000; glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
    glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000; glyph[8]  = 7'b0000000;
    glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110;
    glyph[15] = 7'b0001110;
  end

  typedef struct {
    logic       rst;
    logic       load;
    logic [3:0] pat;
    logic       valid;
    logic       b;
    logic       ovl;
    logic       exp_match;
    logic [7:0] exp_count;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic ld, input logic [3:0] p, input logic v,
                      input logic b, input logic o);
    @(negedge clk);
    rst = r; load_pat = ld; pattern = p; bit_valid = v; bit_in = b; overlap = o;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic ld, input logic [3:0] p,
                              input logic v, input logic b, input logic o,
                              input logic em, input logic [7:0] ec, input logic eb);
    vec_t t;
    t.rst = r; t.load = ld; t.pat = p; t.valid = v; t.b = b; t.ovl = o;
    t.exp_match = em; t.exp_count = ec; t.exp_busy = eb;
    return t;
  endfunction

  int pulses;

  initial begin
    rst = 1'b1; load_pat = 1'b0; pattern = 4'h0; bit_valid = 1'b0; bit_in = 1'b0;
    overlap = 1'b1;

    // Overlap, default pattern 1011, stream 1011011.
    vecs.push_back(mk(0,0,4'h0,1,1,1, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,0,1, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,1,1, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,1,1, 1,8'd1,1));
    vecs.push_back(mk(0,0,4'h0,1,0,1, 0,8'd1,1));
    vecs.push_back(mk(0,0,4'h0,1,1,1, 0,8'd1,1));
    vecs.push_back(mk(0,0,4'h0,1,1,1, 1,8'd2,1));
    // Reload 1011, then non-overlap on the same stream.
    vecs.push_back(mk(0,1,4'b1011,0,0,0, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,1,0, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,0,0, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,1,0, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,1,0, 1,8'd1,0));
    vecs.push_back(mk(0,0,4'h0,1,0,0, 0,8'd1,0));
    vecs.push_back(mk(0,0,4'h0,1,1,0, 0,8'd1,0));
    vecs.push_back(mk(0,0,4'h0,1,1,0, 0,8'd1,0));
    // Idle cycle holds everything.
    vecs.push_back(mk(0,0,4'h0,0,1,0, 0,8'd1,0));
    // Load 0110 with a simultaneous valid bit: bit dropped.
    vecs.push_back(mk(0,1,4'b0110,1,1,1, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,0,1, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,1,1, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,1,1, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,0,1, 1,8'd1,1));
    // RST on the 3rd bit of 1011, then a full fresh 1011 is required.
    vecs.push_back(mk(0,1,4'b1011,0,0,1, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,1,1, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,0,1, 0,8'd0,0));
    vecs.push_back(mk(1,0,4'h0,1,1,1, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,1,1, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,0,1, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,1,1, 0,8'd0,0));
    vecs.push_back(mk(0,0,4'h0,1,1,1, 1,8'd1,1));
    // RST on the cycle that would complete a match.
    vecs.push_back(mk(0,0,4'h0,1,0,1, 0,8'd1,1));
    vecs.push_back(mk(0,0,4'h0,1,1,1, 0,8'd1,1));
    vecs.push_back(mk(1,0,4'h0,1,1,1, 0,8'd0,0));

    // Reset for two cycles, then check the idle state.
    step(1,0,4'h0,0,0,1);
    step(1,0,4'h0,0,0,1);
    step(0,0,4'h0,0,0,1);
    check("reset_match", 0, 32'(match), 32'd0);
    check("reset_count", 0, 32'(match_count), 32'd0);
    check("reset_busy",  0, 32'(busy), 32'd0);
    check("reset_hex0",  0, 32'(hex0), 32'(7'b1000000));
    check("reset_hex1",  0, 32'(hex1), 32'(7'b1000000));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].load, vecs[i].pat, vecs[i].valid, vecs[i].b, vecs[i].ovl);
      check("match", i, 32'(match), 32'(vecs[i].exp_match));
      check("count", i, 32'(match_count), 32'(vecs[i].exp_count));
      check("busy",  i, 32'(busy), 32'(vecs[i].exp_busy));
      check("hex0",  i, 32'(hex0), 32'(glyph[vecs[i].exp_count[3:0]]));
      check("hex1",  i, 32'(hex1), 32'(glyph[vecs[i].exp_count[7:4]]));
    end

    // Saturation: pattern 1111, overlap, 261 ones -> 258 pulses, count stops at FF.
    step(0,1,4'b1111,0,0,1);
    pulses = 0;
    for (int n = 1; n <= 261; n++) begin
      step(0,0,4'h0,1,1,1);
      if (match) pulses++;
      if (n == 257) check("sat_count_257", n, 32'(match_count), 32'hFE);
      if (n == 258) check("sat_count_258", n, 32'(match_count), 32'hFF);
    end
    check("sat_pulses", 0, 32'(pulses), 32'd258);
    check("sat_match",  0, 32'(match), 32'd1);
    check("sat_count",  0, 32'(match_count), 32'hFF);
    check("sat_hex0",   0, 32'(hex0), 32'(7'b0001110));
    check("sat_hex1",   0, 32'(hex1), 32'(7'b0001110));
    step(0,0,4'h0,0,0,1);
    check("sat_pulse_drop", 0, 32'(match), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
